// File: rtl/oram_pkg.sv
// oram_pkg: shared types for the ORAM Avalon bridge.
//   oram_bridge_state_t : bridge sequencer states
//   oram_word_t         : one bus word / ORAM block payload (default geometry)
//   oram_block_t        : ORAM block number (default geometry)
package oram_pkg;

   localparam int ORAM_ADDRESS_WIDTH  = 4;
   localparam int ORAM_BYTE_WIDTH     = 8;
   localparam int ORAM_BYTES_PER_WORD = 4;
   localparam int ORAM_WORD_WIDTH     = ORAM_BYTES_PER_WORD * ORAM_BYTE_WIDTH;
   localparam int ORAM_TREE_DEPTH     = $clog2((1 << ORAM_ADDRESS_WIDTH) / ORAM_BYTES_PER_WORD);

   typedef logic [ORAM_WORD_WIDTH-1:0] oram_word_t;
   typedef logic [ORAM_TREE_DEPTH-1:0] oram_block_t;

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      WR_ISSUE,
      WR_WAIT,
      DONE
   } oram_bridge_state_t;

endpackage

// File: rtl/oram_byte_merge.sv
// oram_byte_merge: combinational byte-lane merge for read-modify-write.
//   old_word   in  : word currently held by the core
//   new_word   in  : bus write data
//   byteenable in  : lanes taken from new_word (others from old_word)
//   merged     out : resulting word
module oram_byte_merge #(
   parameter int BYTE_WIDTH     = 8,
   parameter int BYTES_PER_WORD = 4
) (
   input  logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] old_word,
   input  logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] new_word,
   input  logic [BYTES_PER_WORD-1:0]            byteenable,
   output logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] merged
);

   for (genvar g = 0; g < BYTES_PER_WORD; g++) begin : g_lane
      assign merged[g*BYTE_WIDTH +: BYTE_WIDTH] = byteenable[g] ? new_word[g*BYTE_WIDTH +: BYTE_WIDTH]
                                                                : old_word[g*BYTE_WIDTH +: BYTE_WIDTH];
   end

endmodule

// File: rtl/oram_avalon_bridge.sv
// oram_avalon_bridge: sequences Avalon-MM accesses into single-pulse ORAM core commands.
//   clock, reset (async, active-low)
//   avs_a_*          : Avalon-MM slave (waitrequest low only in the completion cycle)
//   rw_block_number, w_value, rw_indicator, input_ready : registered core command
//   r_value, output_ready                               : core result
// Build option: define ORAM_BRIDGE_RMW_EN to turn partial-byteenable writes into
// read-modify-write sequences (and complete byteenable==0 writes without a core access).
module oram_avalon_bridge
   import oram_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 4,
   parameter int BYTE_WIDTH     = 8,
   parameter int BYTES_PER_WORD = 4,
   parameter int TREE_DEPTH     = $clog2((1 << ADDRESS_WIDTH) / BYTES_PER_WORD)
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [ADDRESS_WIDTH-1:0]             avs_a_address,
   input  logic [BYTES_PER_WORD-1:0]            avs_a_byteenable,
   input  logic                                 avs_a_read,
   input  logic                                 avs_a_write,
   input  logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] avs_a_writedata,
   output logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] avs_a_readdata,
   output logic                                 avs_a_waitrequest,
   output logic [TREE_DEPTH-1:0]                rw_block_number,
   output logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] w_value,
   output logic                                 rw_indicator,
   output logic                                 input_ready,
   input  logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] r_value,
   input  logic                                 output_ready
);

   localparam int WORD_WIDTH = BYTES_PER_WORD * BYTE_WIDTH;

   oram_bridge_state_t state;

`ifdef ORAM_BRIDGE_RMW_EN
   logic [WORD_WIDTH-1:0]     data_q;
   logic [BYTES_PER_WORD-1:0] be_q;
   logic                      wr_q;
   logic [WORD_WIDTH-1:0]     merged;
   logic                      unused_in;

   // byte offset bits never select anything: accesses are whole words
   assign unused_in = ^avs_a_address[ADDRESS_WIDTH-TREE_DEPTH-1:0];

   oram_byte_merge #(
      .BYTE_WIDTH    (BYTE_WIDTH),
      .BYTES_PER_WORD(BYTES_PER_WORD)
   ) u_merge (
      .old_word  (r_value),
      .new_word  (data_q),
      .byteenable(be_q),
      .merged    (merged)
   );
`else
   logic unused_in;

   // without RMW every write is a full-word write, so lanes are irrelevant
   assign unused_in = ^{avs_a_address[ADDRESS_WIDTH-TREE_DEPTH-1:0], avs_a_byteenable};
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state             <= IDLE;
         avs_a_readdata    <= '0;
         avs_a_waitrequest <= 1'b1;
         rw_block_number   <= '0;
         w_value           <= '0;
         rw_indicator      <= 1'b0;
         input_ready       <= 1'b0;
`ifdef ORAM_BRIDGE_RMW_EN
         data_q            <= '0;
         be_q              <= '0;
         wr_q              <= 1'b0;
`endif
      end else begin
         input_ready       <= 1'b0;
         avs_a_waitrequest <= 1'b1;
         case (state)
            IDLE: begin
               if (avs_a_read | avs_a_write) begin
                  rw_block_number <= avs_a_address[ADDRESS_WIDTH-1 -: TREE_DEPTH];
`ifdef ORAM_BRIDGE_RMW_EN
                  data_q <= avs_a_writedata;
                  be_q   <= avs_a_byteenable;
                  wr_q   <= avs_a_write;
                  // a write with no lanes enabled touches nothing; a partial one
                  // first fetches the old block so the untouched lanes survive
                  if (avs_a_write && ~|avs_a_byteenable) begin
                     avs_a_waitrequest <= 1'b0;
                     state             <= DONE;
                  end else if (avs_a_write && &avs_a_byteenable) begin
                     w_value      <= avs_a_writedata;
                     rw_indicator <= 1'b1;
                     input_ready  <= 1'b1;
                     state        <= WR_ISSUE;
                  end else begin
                     input_ready <= 1'b1;
                     state       <= RD_ISSUE;
                  end
`else
                  if (avs_a_write) begin
                     w_value      <= avs_a_writedata;
                     rw_indicator <= 1'b1;
                     input_ready  <= 1'b1;
                     state        <= WR_ISSUE;
                  end else begin
                     input_ready <= 1'b1;
                     state       <= RD_ISSUE;
                  end
`endif
               end
            end
            RD_ISSUE: state <= RD_WAIT;
            RD_WAIT: begin
               if (output_ready) begin
`ifdef ORAM_BRIDGE_RMW_EN
                  if (wr_q) begin
                     w_value      <= merged;
                     rw_indicator <= 1'b1;
                     input_ready  <= 1'b1;
                     state        <= WR_ISSUE;
                  end else
`endif
                  begin
                     avs_a_readdata    <= r_value;
                     avs_a_waitrequest <= 1'b0;
                     state             <= DONE;
                  end
               end
            end
            WR_ISSUE: state <= WR_WAIT;
            WR_WAIT: begin
               if (output_ready) begin
                  rw_indicator      <= 1'b0;
                  avs_a_waitrequest <= 1'b0;
                  state             <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_oram_avalon_bridge.sv
// tb_oram_avalon_bridge: directed table plus randomized transactions against a word-level memory model.
module tb_oram_avalon_bridge;
   import oram_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  avs_a_address = '0;
   logic [3:0]  avs_a_byteenable = '0;
   logic        avs_a_read = 1'b0;
   logic        avs_a_write = 1'b0;
   oram_word_t  avs_a_writedata = '0;
   oram_word_t  avs_a_readdata;
   logic        avs_a_waitrequest;
   oram_block_t rw_block_number;
   oram_word_t  w_value;
   logic        rw_indicator;
   logic        input_ready;
   oram_word_t  r_value = '0;
   logic        output_ready = 1'b0;

   oram_avalon_bridge dut (
      .clock            (clock),
      .reset            (reset),
      .avs_a_address    (avs_a_address),
      .avs_a_byteenable (avs_a_byteenable),
      .avs_a_read       (avs_a_read),
      .avs_a_write      (avs_a_write),
      .avs_a_writedata  (avs_a_writedata),
      .avs_a_readdata   (avs_a_readdata),
      .avs_a_waitrequest(avs_a_waitrequest),
      .rw_block_number  (rw_block_number),
      .w_value          (w_value),
      .rw_indicator     (rw_indicator),
      .input_ready      (input_ready),
      .r_value          (r_value),
      .output_ready     (output_ready)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // core stub: result appears lat_cfg+1 cycles after the start pulse
   oram_word_t  core_mem [4];
   int          lat_cfg = 3;
   int          ir_count = 0;
   int          overlap = 0;
   bit          busy = 0;
   int          cnt = 0;
   bit          spur = 0;
   oram_block_t s_blk;
   logic        s_rw;
   oram_word_t  s_wv;
   oram_word_t  last_wv = '0;
   logic        last_rw = 1'b0;
   oram_block_t last_blk = '0;
   logic [7:0]  rw_hist = '0;

   always @(negedge clock) begin
      output_ready = spur;
      if (!reset) begin
         busy = 0;
      end else begin
         if (busy) begin
            cnt--;
            if (cnt == 0) begin
               output_ready = 1'b1;
               busy = 0;
               if (s_rw) begin
                  core_mem[s_blk] = s_wv;
                  r_value = $urandom;
               end else begin
                  r_value = core_mem[s_blk];
               end
            end
         end
         if (input_ready) begin
            if (busy) overlap++;
            busy = 1;
            cnt = lat_cfg + 1;
            s_blk = rw_block_number;
            s_rw = rw_indicator;
            s_wv = w_value;
            ir_count++;
            last_wv = w_value;
            last_rw = rw_indicator;
            last_blk = rw_block_number;
            rw_hist = {rw_hist[6:0], rw_indicator};
         end
      end
   end

   // reference model: word memory and last expected readdata
   oram_word_t ref_mem [4];
   oram_word_t exp_rd = '0;

   function automatic oram_word_t merge_ref(input oram_word_t o, input oram_word_t n, input logic [3:0] b);
      oram_word_t m = o;
      for (int i = 0; i < 4; i++) if (b[i]) m[8*i +: 8] = n[8*i +: 8];
      return m;
   endfunction

   function automatic void predict(input bit w, input logic [3:0] b, input int l, input oram_word_t old,
                                   input oram_word_t d, output int lat, output int acc, output oram_word_t nv);
      lat = 3 + l;
      acc = 1;
      nv = old;
      if (w) begin
`ifdef ORAM_BRIDGE_RMW_EN
         if (b == 4'h0) begin
            lat = 1;
            acc = 0;
         end else if (b == 4'hF) begin
            nv = d;
         end else begin
            lat = 5 + 2 * l;
            acc = 2;
            nv = merge_ref(old, d, b);
         end
`else
         nv = d;
`endif
      end
   endfunction

   task automatic txn(input bit r, input bit w, input logic [3:0] a, input logic [3:0] b, input oram_word_t d,
                      output int lat, output int acc, output bit timeout);
      int ir0;
      @(negedge clock);
      avs_a_read = r;
      avs_a_write = w;
      avs_a_address = a;
      avs_a_byteenable = b;
      avs_a_writedata = d;
      ir0 = ir_count;
      lat = 0;
      timeout = 1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clock);
         lat++;
         @(negedge clock);
         if (!avs_a_waitrequest) begin
            timeout = 0;
            break;
         end
      end
      acc = ir_count - ir0;
      avs_a_read = 1'b0;
      avs_a_write = 1'b0;
   endtask

   task automatic run(input bit r, input bit w, input logic [3:0] a, input logic [3:0] b, input oram_word_t d,
                      input int l);
      int lat, acc, elat, eacc;
      bit to;
      oram_word_t nv;
      int blkn = int'(a[3:2]);
      predict(w, b, l, ref_mem[blkn], d, elat, eacc, nv);
      lat_cfg = l;
      txn(r, w, a, b, d, lat, acc, to);
      chk("timeout", 32'(to), 0);
      chk("latency", lat, elat);
      chk("accesses", acc, eacc);
      if (w) begin
         ref_mem[blkn] = nv;
         if (eacc > 0) begin
            chk("w_value", last_wv, nv);
            chk("rw_indicator_wr", 32'(last_rw), 1);
            chk("block_wr", 32'(last_blk), blkn);
         end
         if (eacc == 2) chk("rmw_order", 32'(rw_hist[1:0]), 32'b01);
         chk("readdata_hold", avs_a_readdata, exp_rd);
      end else begin
         exp_rd = ref_mem[blkn];
         chk("readdata", avs_a_readdata, exp_rd);
         chk("rw_indicator_rd", 32'(last_rw), 0);
         chk("block_rd", 32'(last_blk), blkn);
      end
   endtask

   typedef struct {
      bit         r;
      bit         w;
      logic [3:0] a;
      logic [3:0] b;
      oram_word_t d;
      int         l;
      oram_word_t data;
      int         lat;
      int         acc;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int lat, acc, elat, eacc, blkn, ir0, rounds;
      bit to;
      oram_word_t nv;

      tbl[0] = '{1, 0, 4'hC, 4'hF, 32'h0,        3, 32'hDEADBEEF, 6, 1};
      tbl[1] = '{0, 1, 4'h4, 4'hF, 32'h11223344, 3, 32'h11223344, 6, 1};
      tbl[2] = '{1, 0, 4'h4, 4'hF, 32'h0,        3, 32'h11223344, 6, 1};
      tbl[3] = '{0, 1, 4'h8, 4'hF, 32'h12345678, 0, 32'h12345678, 3, 1};
`ifdef ORAM_BRIDGE_RMW_EN
      tbl[4] = '{0, 1, 4'h8, 4'h3, 32'hAAAABBBB, 1, 32'h1234BBBB, 7, 2};
      tbl[5] = '{1, 0, 4'h8, 4'hF, 32'h0,        2, 32'h1234BBBB, 5, 1};
      tbl[6] = '{0, 1, 4'h8, 4'h0, 32'h55555555, 3, 32'h0,        1, 0};
      tbl[7] = '{1, 0, 4'h8, 4'hF, 32'h0,        0, 32'h1234BBBB, 3, 1};
`else
      tbl[4] = '{0, 1, 4'h8, 4'h3, 32'hAAAABBBB, 1, 32'hAAAABBBB, 4, 1};
      tbl[5] = '{1, 0, 4'h8, 4'hF, 32'h0,        2, 32'hAAAABBBB, 5, 1};
      tbl[6] = '{0, 1, 4'h8, 4'h0, 32'h55555555, 3, 32'h55555555, 6, 1};
      tbl[7] = '{1, 0, 4'h8, 4'hF, 32'h0,        0, 32'h55555555, 3, 1};
`endif
      tbl[8] = '{1, 1, 4'h0, 4'hF, 32'hCAFEF00D, 1, 32'hCAFEF00D, 4, 1};
      tbl[9] = '{1, 0, 4'h0, 4'hF, 32'h0,        4, 32'hCAFEF00D, 7, 1};

      for (int i = 0; i < 4; i++) begin
         core_mem[i] = '0;
         ref_mem[i] = '0;
      end
      core_mem[3] = 32'hDEADBEEF;
      ref_mem[3] = 32'hDEADBEEF;

      #1 reset = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_waitrequest", 32'(avs_a_waitrequest), 1);
      chk("rst_input_ready", 32'(input_ready), 0);
      chk("rst_rw_indicator", 32'(rw_indicator), 0);
      chk("rst_readdata", avs_a_readdata, 0);
      chk("rst_w_value", w_value, 0);
      chk("rst_block", 32'(rw_block_number), 0);
      reset = 1'b1;

      for (int i = 0; i < 10; i++) begin
         if (i == 8) begin
            // stray core result while idle must be ignored
            ir0 = ir_count;
            @(posedge clock);
            #1 spur = 1;
            @(posedge clock);
            #1 spur = 0;
            repeat (3) begin
               @(negedge clock);
               chk("spur_waitrequest", 32'(avs_a_waitrequest), 1);
               chk("spur_no_issue", ir_count, ir0);
            end
         end
         blkn = int'(tbl[i].a[3:2]);
         predict(tbl[i].w, tbl[i].b, tbl[i].l, ref_mem[blkn], tbl[i].d, elat, eacc, nv);
         lat_cfg = tbl[i].l;
         txn(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].d, lat, acc, to);
         chk($sformatf("v%0d_timeout", i), 32'(to), 0);
         chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
         chk($sformatf("v%0d_accesses", i), acc, tbl[i].acc);
         if (tbl[i].acc > 0) chk($sformatf("v%0d_block", i), 32'(last_blk), blkn);
         if (tbl[i].w) begin
            ref_mem[blkn] = nv;
            if (tbl[i].acc > 0) begin
               chk($sformatf("v%0d_w_value", i), last_wv, tbl[i].data);
               chk($sformatf("v%0d_rw_indicator", i), 32'(last_rw), 1);
            end
            if (tbl[i].acc == 2) chk($sformatf("v%0d_rmw_order", i), 32'(rw_hist[1:0]), 32'b01);
            chk($sformatf("v%0d_readdata_hold", i), avs_a_readdata, exp_rd);
         end else begin
            exp_rd = tbl[i].data;
            chk($sformatf("v%0d_readdata", i), avs_a_readdata, tbl[i].data);
            chk($sformatf("v%0d_rw_indicator", i), 32'(last_rw), 0);
         end
      end

      // reset while the core read is outstanding
      lat_cfg = 5;
      @(negedge clock);
      avs_a_read = 1'b1;
      avs_a_address = 4'hC;
      rounds = 0;
      while (!input_ready && rounds < 10) begin
         @(negedge clock);
         rounds++;
      end
      chk("midrst_issue_seen", 32'(input_ready), 1);
      @(negedge clock);
      avs_a_read = 1'b0;
      reset = 1'b0;
      #1;
      chk("midrst_waitrequest", 32'(avs_a_waitrequest), 1);
      chk("midrst_input_ready", 32'(input_ready), 0);
      chk("midrst_readdata", avs_a_readdata, 0);
      chk("midrst_rw_indicator", 32'(rw_indicator), 0);
      ir0 = ir_count;
      repeat (2) begin
         @(negedge clock);
         chk("midrst_hold_wait", 32'(avs_a_waitrequest), 1);
      end
      reset = 1'b1;
      exp_rd = '0;
      repeat (3) @(negedge clock);
      chk("midrst_no_issue", ir_count, ir0);
      run(1, 0, 4'hC, 4'hF, 32'h0, 2);

      for (int i = 0; i < 40; i++) begin
         bit r, w;
         logic [3:0] b;
         int sel;
         r = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         if (!r && !w) r = 1;
         sel = $urandom_range(0, 3);
         b = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom);
         run(r, w, 4'($urandom), b, $urandom, $urandom_range(0, 4));
      end

      chk("no_overlap", overlap, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
